sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
- Shares one SRAM-like request port (req/wr/size/wstrb/addr/wdata, addr_ok/data_ok/rdata) between NUM_MST upstream masters, e.g. uncached data path and store buffer, in front of the AXI bridge's data_sram channel.
- Arbitrates round-robin and holds the grant until the address handshake completes.
- Records the grantee of every accepted request in an in-order FIFO so that each downstream data_ok is routed back to the correct master.

Parameters:
- NUM_MST, 2, number of upstream masters (2..4)
- MAX_OUTST, 4, maximum accepted-but-unanswered requests (power of two, 2..8)
- IDX_W, $clog2(NUM_MST), grantee index width (derived)

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- m_req  in  NUM_MST  per-master request
- m_wr  in  NUM_MST  per-master write flag
- m_size  in  2*NUM_MST  per-master size, master i at [2i+1:2i]
- m_wstrb  in  4*NUM_MST  per-master byte strobe
- m_addr  in  32*NUM_MST  per-master address
- m_wdata  in  32*NUM_MST  per-master write data
- m_addr_ok  out  NUM_MST  one-hot address accept
- m_data_ok  out  NUM_MST  one-hot response
- m_rdata  out  32  read data, shared by all masters
- s_req  out  1  downstream request
- s_wr  out  1  downstream write flag
- s_size  out  2  downstream size
- s_wstrb  out  4  downstream byte strobe
- s_addr  out  32  downstream address
- s_wdata  out  32  downstream write data
- s_addr_ok  in  1  downstream address accept
- s_data_ok  in  1  downstream response
- s_rdata  in  32  downstream read data
- outst_cnt  out  $clog2(MAX_OUTST)+1  current outstanding count
- err_spurious  out  1  sticky: data_ok arrived with the FIFO empty

Behaviour:
- Reset, asynchronous on areset high:
  - rr_ptr=0, lock=0, FIFO empty, outst_cnt=0, err_spurious=0.
  - All outputs are 0 while areset is high.
- Grant:
  - When lock=0, grant_idx is the first requesting master at or after rr_ptr (circular search), computed combinationally.
  - When lock=1, grant_idx is the registered locked_idx.
- Downstream request:
  - s_req = m_req[grant_idx] && any requester && !fifo_full.
  - All s_* payload fields mux combinationally from grant_idx.
- Locking:
  - If s_req=1 and s_addr_ok=0, set lock=1 and locked_idx=grant_idx next cycle.
  - If the locked master drops m_req, clear lock next cycle. This is defensive; masters must hold req.
- Address handshake (s_req && s_addr_ok):
  - m_addr_ok[grant_idx]=1 in the same cycle, combinationally.
  - Push grant_idx into the FIFO.
  - rr_ptr <= grant_idx+1, mod NUM_MST.
  - Clear lock.
- FIFO full:
  - s_req=0 and m_addr_ok=0 for all masters.
  - Grant does not advance. lock is not set by a full stall.
- Response:
  - On s_data_ok with the FIFO non-empty, m_data_ok[head]=1 combinationally and the FIFO pops.
  - m_rdata = s_rdata always.
  - One response per cycle; responses are in order.
- Spurious response: s_data_ok with the FIFO empty pops nothing, drives m_data_ok=0, and sets err_spurious (sticky until reset).
- Simultaneous push and pop:
  - outst_cnt is unchanged and both pointers advance.
  - When full, a same-cycle pop does NOT enable a push. The full check uses the registered count, which breaks the comb loop with s_data_ok.
- Pointers: wrap modulo MAX_OUTST. outst_cnt ranges 0..MAX_OUTST and never exceeds it.
- Zero-latency path: s_addr_ok→m_addr_ok and s_data_ok→m_data_ok are combinational. There is no registered latency in the request or response path.
- Reset mid-operation: outstanding entries are discarded. Any later s_data_ok is flagged err_spurious, so the downstream must be reset together with this block.

Decomposition:
- Shared package sram_if_pkg: size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2) and a struct for the request payload {wr, size, wstrb, addr, wdata}.
- One sub-module: sram_grant_fifo, a parameterized sync FIFO of IDX_W-wide entries with full/empty/count outputs and async active-high reset.

Test Plan:
- Single master 0 read at addr 0x1C00_0000, s_addr_ok same cycle, s_data_ok 3 cycles later with 0xDEAD_BEEF → m_addr_ok=2'b01 in cycle 0; m_data_ok=2'b01 with m_rdata=0xDEAD_BEEF in cycle 3; outst_cnt 0→1→0.
- Both masters requesting continuously, s_addr_ok always 1 → grants alternate 0,1,0,1. The four data_ok pulses return in order to masters 0,1,0,1.
- Master 1 granted, s_addr_ok held low for 5 cycles while master 0 raises req → s_* stays master 1's payload for all 5 cycles (lock); master 1 is accepted first, then master 0.
- Fill 4 outstanding with s_data_ok=0 → the 5th request sees s_req=0. In the cycle s_data_ok=1 arrives, still no accept; the accept happens the next cycle and outst_cnt returns to 4.
- areset pulsed with 3 outstanding → outst_cnt=0 and all outputs 0 immediately. The following s_data_ok gives m_data_ok=0 and err_spurious=1, which stays set.
- Write from master 1 (wstrb=4'b0011, size=1, wdata=0x0000_1234) → s_wr=1, s_wstrb=4'b0011, s_size=1, s_wdata=0x0000_1234; data_ok is routed to master 1.

Source files
------------

// File: rtl/sram_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_if_pkg
// Description : Size encodings and request payload type shared by SRAM-port blocks.
// Revision    : 1.0
// ============================================================================
package sram_if_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage
`default_nettype wire

// File: rtl/sram_grant_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_grant_fifo
// Description : Synchronous FIFO of grantee indices with full/empty/count flags.
// Revision    : 1.0
// ============================================================================
module sram_grant_fifo #(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Full comes from the registered count only, so a same-cycle pop never frees a slot.
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_req_arbiter
// Description : Round-robin sharing of one SRAM request port among NUM_MST masters,
//               with in-order routing of responses back to the accepted master.
// Revision    : 1.0
// ============================================================================
module sram_req_arbiter
    import sram_if_pkg::*;
#(
    parameter  int NUM_MST   = 2,
    parameter  int MAX_OUTST = 4,
    localparam int IDX_W     = $clog2(NUM_MST),
    localparam int CNT_W     = $clog2(MAX_OUTST) + 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [NUM_MST-1:0]    m_req,
    input  logic [NUM_MST-1:0]    m_wr,
    input  logic [2*NUM_MST-1:0]  m_size,
    input  logic [4*NUM_MST-1:0]  m_wstrb,
    input  logic [32*NUM_MST-1:0] m_addr,
    input  logic [32*NUM_MST-1:0] m_wdata,
    output logic [NUM_MST-1:0]    m_addr_ok,
    output logic [NUM_MST-1:0]    m_data_ok,
    output logic [31:0]           m_rdata,
    output logic                  s_req,
    output logic                  s_wr,
    output logic [1:0]            s_size,
    output logic [3:0]            s_wstrb,
    output logic [31:0]           s_addr,
    output logic [31:0]           s_wdata,
    input  logic                  s_addr_ok,
    input  logic                  s_data_ok,
    input  logic [31:0]           s_rdata,
    output logic [CNT_W-1:0]      outst_cnt,
    output logic                  err_spurious
);

    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_lock;
    logic [IDX_W-1:0] r_locked_idx;
    logic             r_err;

    sram_req_t        w_pl [NUM_MST];
    sram_req_t        w_sel;
    logic [IDX_W-1:0] w_rr_idx;
    logic [IDX_W-1:0] w_grant_idx;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_any;
    logic             w_s_req;
    logic             w_accept;
    logic             w_pop;
    logic             w_spurious;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;

    // First requester at or after ptr, searching circularly.
    function automatic logic [IDX_W-1:0] f_rr_pick(
        input logic [NUM_MST-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               cand;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_MST; k++) begin
            cand = (int'(ptr) + k) % NUM_MST;
            if (!found && req[cand[IDX_W-1:0]]) begin
                pick  = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_unpack
            assign w_pl[gi] = {m_wr[gi], m_size[2*gi +: 2], m_wstrb[4*gi +: 4],
                               m_addr[32*gi +: 32], m_wdata[32*gi +: 32]};
        end
    endgenerate

    assign w_any       = |m_req;
    assign w_rr_idx    = f_rr_pick(m_req, r_rr_ptr);
    assign w_grant_idx = r_lock ? r_locked_idx : w_rr_idx;
    assign w_sel       = w_pl[w_grant_idx];

    assign w_s_req    = w_any && m_req[w_grant_idx] && !w_fifo_full;
    assign w_accept   = w_s_req && s_addr_ok;
    assign w_pop      = s_data_ok && !w_fifo_empty;
    assign w_spurious = s_data_ok && w_fifo_empty;

    sram_grant_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTST)
    ) u_grant_fifo (
        .clk     (aclk),
        .rst     (areset),
        .i_push  (w_accept),
        .i_wdata (w_grant_idx),
        .i_pop   (w_pop),
        .o_rdata (w_head_idx),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Every output is forced low while reset is asserted, including the pass-through paths.
    assign s_req   = w_s_req && !areset;
    assign s_wr    = areset ? 1'b0  : w_sel.wr;
    assign s_size  = areset ? 2'b00 : w_sel.size;
    assign s_wstrb = areset ? 4'h0  : w_sel.wstrb;
    assign s_addr  = areset ? 32'h0 : w_sel.addr;
    assign s_wdata = areset ? 32'h0 : w_sel.wdata;
    assign m_rdata = areset ? 32'h0 : s_rdata;

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        if (w_accept && !areset) m_addr_ok[w_grant_idx] = 1'b1;
        if (w_pop && !areset)    m_data_ok[w_head_idx]  = 1'b1;
    end

    assign outst_cnt    = w_fifo_count;
    assign err_spurious = r_err;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rr_ptr     <= '0;
            r_lock       <= 1'b0;
            r_locked_idx <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_spurious) r_err <= 1'b1;
            if (w_accept) begin
                r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_MST - 1)) ? '0 : w_grant_idx + IDX_W'(1);
                r_lock   <= 1'b0;
            end else if (w_s_req) begin
                r_lock       <= 1'b1;
                r_locked_idx <= w_grant_idx;
            end else if (r_lock && !m_req[r_locked_idx]) begin
                r_lock <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_req_arbiter
// Description : Randomized scoreboard bench for sram_req_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_sram_req_arbiter;
    import sram_if_pkg::*;

    localparam int N      = 3;
    localparam int MO     = 4;
    localparam int CW     = $clog2(MO) + 1;
    localparam int CYCLES = 3000;
    localparam int RST_AT = 1500;

    logic            aclk = 1'b0;
    logic            areset;
    logic [N-1:0]    m_req;
    logic [N-1:0]    m_wr;
    logic [2*N-1:0]  m_size;
    logic [4*N-1:0]  m_wstrb;
    logic [32*N-1:0] m_addr;
    logic [32*N-1:0] m_wdata;
    logic [N-1:0]    m_addr_ok;
    logic [N-1:0]    m_data_ok;
    logic [31:0]     m_rdata;
    logic            s_req;
    logic            s_wr;
    logic [1:0]      s_size;
    logic [3:0]      s_wstrb;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic            s_addr_ok;
    logic            s_data_ok;
    logic [31:0]     s_rdata;
    logic [CW-1:0]   outst_cnt;
    logic            err_spurious;

    sram_req_arbiter #(.NUM_MST(N), .MAX_OUTST(MO)) dut (
        .aclk(aclk), .areset(areset),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outst_cnt(outst_cnt), .err_spurious(err_spurious)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int          mst;
        logic [31:0] rdata;
    } rsp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    sram_req_t   pl [N];
    logic [N-1:0] req_v;
    logic [N-1:0] acc_mask;
    rsp_t        exp_q [$];
    logic [31:0] slave_q [$];

    // Reference arbitration state, expressed as plain integers.
    int ref_rr;
    bit ref_lock;
    int ref_lidx;
    bit ref_err;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic sram_req_t rand_req();
        sram_req_t r;
        r.wr = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
            0:       r.size = SZ_BYTE;
            1:       r.size = SZ_HALF;
            default: r.size = SZ_WORD;
        endcase
        r.wstrb = 4'($urandom);
        r.addr  = $urandom;
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            m_req[i]           = req_v[i];
            m_wr[i]            = pl[i].wr;
            m_size[2*i +: 2]   = pl[i].size;
            m_wstrb[4*i +: 4]  = pl[i].wstrb;
            m_addr[32*i +: 32] = pl[i].addr;
            m_wdata[32*i +: 32] = pl[i].wdata;
        end
    endtask

    // Stimulus: masters hold a request until accepted; downstream answers randomly.
    initial begin
        areset    = 1'b1;
        req_v     = '0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        s_rdata   = '0;
        for (int i = 0; i < N; i++) pl[i] = rand_req();
        drive_masters();
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge aclk);
            #1;
            req_v = req_v & ~acc_mask;
            if (cyc >= RST_AT && cyc < RST_AT + 2) begin
                areset = 1'b1;
                req_v  = '0;
                slave_q.delete();
                for (int i = 0; i < N; i++) req_v[i] = 1'b1;
                s_addr_ok = 1'b1;
                s_data_ok = 1'b1;
                s_rdata   = $urandom;
                drive_masters();
                req_v = '0;
                continue;
            end
            if (cyc == RST_AT + 2) begin
                areset    = 1'b0;
                req_v     = '0;
                s_addr_ok = 1'b0;
                s_data_ok = 1'b1;
                s_rdata   = $urandom;
                drive_masters();
                continue;
            end
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && $urandom_range(0, 3) != 0) begin
                    req_v[i] = 1'b1;
                    pl[i]    = rand_req();
                end
            end
            s_addr_ok = 1'($urandom_range(0, 1));
            if (slave_q.size() > 0 &&
                ((cyc % 500 < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0))) begin
                s_data_ok = 1'b1;
                s_rdata   = slave_q.pop_front();
            end else begin
                s_data_ok = 1'b0;
                s_rdata   = $urandom;
            end
            drive_masters();
        end
        @(negedge aclk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Monitor and scoreboard: compares the DUT against the reference rules each cycle.
    int           g;
    bit           full;
    bit           exp_sreq;
    bit           acc;
    bit           pop;
    logic [N-1:0] exp_aok;
    logic [N-1:0] exp_dok;
    logic [31:0]  rd;

    initial begin
        acc_mask = '0;
        ref_rr   = 0;
        ref_lock = 1'b0;
        ref_lidx = 0;
        ref_err  = 1'b0;
    end

    always @(negedge aclk) begin
        if (areset) begin
            check("reset_outputs",
                  {m_addr_ok, m_data_ok, m_rdata, s_req, s_wr, s_size, s_wstrb,
                   s_addr, s_wdata, outst_cnt, err_spurious}, '0);
            exp_q.delete();
            ref_rr   = 0;
            ref_lock = 1'b0;
            ref_lidx = 0;
            ref_err  = 1'b0;
            acc_mask = '0;
        end else begin
            if (ref_lock) begin
                g = ref_lidx;
            end else begin
                g = ref_rr;
                for (int k = N - 1; k >= 0; k--)
                    if (m_req[(ref_rr + k) % N]) g = (ref_rr + k) % N;
            end
            full     = (exp_q.size() >= MO);
            exp_sreq = (|m_req) && m_req[g] && !full;
            check("s_req", s_req, exp_sreq);
            if (exp_sreq)
                check("payload", {s_wr, s_size, s_wstrb, s_addr, s_wdata}, pl[g]);
            acc     = exp_sreq && s_addr_ok;
            exp_aok = acc ? N'(1 << g) : '0;
            check("m_addr_ok", m_addr_ok, exp_aok);

            pop     = s_data_ok && (exp_q.size() > 0);
            exp_dok = pop ? N'(1 << exp_q[0].mst) : '0;
            check("m_data_ok", m_data_ok, exp_dok);
            if (pop) check("rsp_rdata", m_rdata, exp_q[0].rdata);
            check("m_rdata", m_rdata, s_rdata);
            check("outst_cnt", outst_cnt, exp_q.size());
            check("err_spurious", err_spurious, ref_err);

            if (s_data_ok && exp_q.size() == 0) ref_err = 1'b1;
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                rd = $urandom;
                exp_q.push_back('{g, rd});
                slave_q.push_back(rd);
                ref_rr   = (g + 1) % N;
                ref_lock = 1'b0;
            end else if (exp_sreq) begin
                ref_lock = 1'b1;
                ref_lidx = g;
            end else if (ref_lock && !m_req[ref_lidx]) begin
                ref_lock = 1'b0;
            end
            acc_mask = exp_aok;
        end
    end

endmodule
`default_nettype wire
